// File: rtl/alu_mult_sequencer.sv
// Iterative shift-add multiplier that borrows the shared ALU adder for one ADD per step.
// Optional early termination when the remaining multiplier bits are zero: EARLY_TERM_EN.
module alu_mult_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [3:0]  OP_ADD  = 4'b0011,
  parameter logic [3:0]  OP_IDLE = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_own,
  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0] mcand, mcand_next;
  logic [WIDTH-1:0] mplier, mplier_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] product_next;
  logic             last_step;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      mcand   <= mcand_next;
      mplier  <= mplier_next;
      count   <= count_next;
      product <= product_next;
    end
  end

  // Exit condition for the current RUN iteration
  always_comb begin
`ifdef EARLY_TERM_EN
    last_step = (count == CW'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    last_step = (count == CW'(WIDTH - 1));
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_next   = state;
    acc_next     = acc;
    mcand_next   = mcand;
    mplier_next  = mplier;
    count_next   = count;
    product_next = product;
    case (state)
      IDLE: begin
        if (start) begin
          mcand_next  = multiplicand;
          mplier_next = multiplier;
          acc_next    = '0;
          count_next  = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        acc_next    = mplier[0] ? alu_result : acc;
        mcand_next  = {mcand[WIDTH-2:0], 1'b0};
        mplier_next = {1'b0, mplier[WIDTH-1:1]};
        count_next  = CW'(count + CW'(1));
        if (last_step) begin
          state_next   = DONE;
          product_next = acc_next;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU steering and status decode from registered state only
  always_comb begin
    busy          = (state != IDLE);
    done          = (state == DONE);
    alu_own       = (state == RUN);
    alu_operation = alu_own ? OP_ADD : OP_IDLE;
    alu_a         = alu_own ? acc : '0;
    alu_b         = alu_own ? mcand : '0;
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench for alu_mult_sequencer: vector table, scoreboard queue, corner sequences.
module tb_alu_mult_sequencer;

  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_IDLE = 4'b0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand, multiplier;
  logic        busy, done, alu_own;
  logic [31:0] product, alu_a, alu_b, alu_result;
  logic [3:0]  alu_operation;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prev_product = 32'h0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  assign alu_result = alu_a + alu_b;

  alu_mult_sequencer #(.WIDTH(32), .OP_ADD(OP_ADD), .OP_IDLE(OP_IDLE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product),
    .alu_own(alu_own), .alu_operation(alu_operation),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [31:0] b);
`ifdef EARLY_TERM_EN
    int hi = 0;
    for (int i = 0; i < 32; i++) if (b[i]) hi = i;
    return hi + 2;
`else
    return 33;
`endif
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_own", 32'(alu_own), 32'd0);
    chk("rst_op", 32'(alu_operation), 32'(OP_IDLE));
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
  endtask

  // Called one step after the accepting edge (cycle 1); follows the op to its done pulse.
  task automatic wait_done(input logic [31:0] a, input int lat, input int inject);
    int cyc = 1;
    bit seen = 0;
    chk("alu_b_first", alu_b, a);
    chk("alu_a_first", alu_a, 32'd0);
    while (!seen && cyc <= lat + 3) begin
      if (inject > 0 && cyc == inject) begin
        start = 1'b1;
        multiplicand = 32'hDEAD_BEEF;
        multiplier = 32'h0000_0100;
      end else if (inject > 0 && cyc == inject + 1) begin
        start = 1'b0;
      end
      chk("own", 32'(alu_own), 32'(cyc < lat));
      chk("busy", 32'(busy), 32'd1);
      chk("op", 32'(alu_operation), alu_own ? 32'(OP_ADD) : 32'(OP_IDLE));
      if (!alu_own) begin
        chk("alu_a_idle", alu_a, 32'd0);
        chk("alu_b_idle", alu_b, 32'd0);
      end
      if (done) begin
        seen = 1;
        chk("latency", 32'(cyc), 32'(lat));
        if (exp_q.size() == 0) begin
          chk("queue_empty", 32'd1, 32'd0);
        end else begin
          prev_product = exp_q.pop_front();
          chk("product", product, prev_product);
        end
      end else begin
        chk("product_held", product, prev_product);
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy !== 1'b0 && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 60) chk("idle_timeout", 32'd0, 32'd1);
    chk("done_single", 32'(done), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] prod, input int inject);
    wait_idle();
    @(negedge clk);
    multiplicand = a;
    multiplier = b;
    start = 1'b1;
    exp_q.push_back(prod);
    @(posedge clk); #1;
    start = 1'b0;
    multiplicand = $urandom;
    multiplier = $urandom;
    wait_done(a, lat_of(b), inject);
  endtask

  initial begin
    int inject_cyc;
    vecs[0] = '{32'd3,         32'd5,         32'd15};
    vecs[1] = '{32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE};
    vecs[2] = '{32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6};
    vecs[3] = '{32'h0000_1234, 32'd0,         32'd0};
    vecs[4] = '{32'h8000_0000, 32'd1,         32'h8000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    vecs[6] = '{32'h0001_0000, 32'h0001_0000, 32'd0};
    vecs[7] = '{32'h0000_DEAD, 32'h0000_0010, 32'h000D_EAD0};
    vecs[8] = '{32'd7,         32'h8000_0000, 32'h8000_0000};

`ifdef EARLY_TERM_EN
    inject_cyc = 2;
`else
    inject_cyc = 10;
`endif

    reset = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].prod, 0);

    // Start pulsed mid-RUN is ignored; next op starts in the IDLE cycle after done
    run_op(32'd3, 32'd5, 32'd15, inject_cyc);
    run_op(32'h0000_1111, 32'd2, 32'h0000_2222, 0);

    // Reset in the middle of RUN aborts the operation
    wait_idle();
    @(negedge clk);
    multiplicand = 32'h55;
    multiplier = 32'h8000_0003;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    prev_product = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    run_op(32'd7, 32'd9, 32'd63, 0);

    wait_idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
